// File: rtl/axi4l_master_cmdq.sv
// AXI4-lite master fed by a small command FIFO; one outstanding transaction,
// one-cycle response pulses, and a B/R watchdog that drains late responses.
module axi4l_master_cmdq #(
  parameter int         ADDR_WIDTH  = 32,
  parameter int         DATA_WIDTH  = 32,
  parameter int         CMD_DEPTH   = 4,
  parameter int         TIMEOUT_CYC = 1024,
  parameter logic [2:0] PROT        = 3'b000
)(
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    M_cmd_valid,
  output logic                    M_cmd_ready,
  input  logic                    M_cmd_wr,
  input  logic [ADDR_WIDTH-1:0]   M_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   M_cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] M_cmd_strb,
  output logic                    M_rsp_valid,
  output logic                    M_rsp_wr,
  output logic [DATA_WIDTH-1:0]   M_rsp_rdata,
  output logic [1:0]              M_rsp_resp,
  output logic                    M_rsp_timeout,
  output logic                    M_busy,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [2:0]              AWPROT,
  output logic                    WVALID,
  input  logic                    WREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    BVALID,
  output logic                    BREADY,
  input  logic [1:0]              BRESP,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [2:0]              ARPROT,
  input  logic                    RVALID,
  output logic                    RREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP
);

  localparam int SW  = DATA_WIDTH/8;
  localparam int PW  = $clog2(CMD_DEPTH);
  localparam int WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [SW-1:0]         strb;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_B, S_RD_A, S_RD_D, S_DRAIN} state_t;

  state_t         r_state, w_next;
  cmd_t           r_fifo [CMD_DEPTH];
  cmd_t           r_cmd, w_head, w_cmd_in;
  logic [PW:0]    r_wptr, r_rptr;
  logic           r_rst_done, r_aw_done, r_w_done;
  logic [WDW-1:0] r_wdog;
  logic           w_empty, w_full, w_push, w_pop;
  logic           w_aw_hs, w_w_hs, w_wdog_hit;

  logic                  r_rsp_valid, r_rsp_wr, r_rsp_timeout;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]            r_rsp_resp;

  assign w_cmd_in   = '{wr: M_cmd_wr, addr: M_cmd_addr, data: M_cmd_wdata, strb: M_cmd_strb};
  assign w_head     = r_fifo[r_rptr[PW-1:0]];
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_push     = M_cmd_valid && M_cmd_ready;
  assign w_aw_hs    = AWVALID && AWREADY;
  assign w_w_hs     = WVALID && WREADY;
  assign w_wdog_hit = (TIMEOUT_CYC != 0) && (r_wdog == WD_LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next = w_head.wr ? S_WR : S_RD_A;
      S_WR:    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = S_WR_B;
      // a response landing on the timeout edge takes priority
      S_WR_B:  if (BVALID) w_next = S_IDLE; else if (w_wdog_hit) w_next = S_DRAIN;
      S_RD_A:  if (ARREADY) w_next = S_RD_D;
      S_RD_D:  if (RVALID) w_next = S_IDLE; else if (w_wdog_hit) w_next = S_DRAIN;
      S_DRAIN: if (r_cmd.wr ? BVALID : RVALID) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    ARVALID = 1'b0;
    BREADY  = 1'b0;
    RREADY  = 1'b0;
    w_pop   = 1'b0;
    case (r_state)
      S_IDLE:  w_pop = !w_empty;
      S_WR:    begin AWVALID = !r_aw_done; WVALID = !r_w_done; end
      S_WR_B:  BREADY = 1'b1;
      S_RD_A:  ARVALID = 1'b1;
      S_RD_D:  RREADY = 1'b1;
      S_DRAIN: begin BREADY = r_cmd.wr; RREADY = !r_cmd.wr; end
      default: ;
    endcase
    M_cmd_ready = r_rst_done && !w_full && (r_state != S_DRAIN);
    M_busy      = (r_state != S_IDLE) || !w_empty;
  end

  // ---------------- command FIFO ----------------
  always_ff @(posedge ACLK) begin
    if (w_push) r_fifo[r_wptr[PW-1:0]] <= w_cmd_in;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // ---------------- active command and channel completion ----------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_cmd     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_pop) begin
      r_cmd     <= w_head;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
    end
  end

  assign AWADDR = r_cmd.addr;
  assign ARADDR = r_cmd.addr;
  assign WDATA  = r_cmd.data;
  assign WSTRB  = r_cmd.strb;
  assign AWPROT = PROT;
  assign ARPROT = PROT;

  // ---------------- watchdog: counts cycles spent waiting for B/R ----------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)                                  r_wdog <= '0;
    else if (r_state == S_WR_B || r_state == S_RD_D) r_wdog <= r_wdog + 1'b1;
    else                                           r_wdog <= '0;
  end

  // ---------------- response pulse ----------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_wr      <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= 2'b00;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_WR_B: if (BVALID || w_wdog_hit) begin
          r_rsp_valid   <= 1'b1;
          r_rsp_wr      <= 1'b1;
          r_rsp_rdata   <= '0;
          r_rsp_resp    <= BVALID ? BRESP : 2'b10;
          r_rsp_timeout <= !BVALID;
        end
        S_RD_D: if (RVALID || w_wdog_hit) begin
          r_rsp_valid   <= 1'b1;
          r_rsp_wr      <= 1'b0;
          r_rsp_rdata   <= RVALID ? RDATA : '0;
          r_rsp_resp    <= RVALID ? RRESP : 2'b10;
          r_rsp_timeout <= !RVALID;
        end
        default: ;
      endcase
    end
  end

  assign M_rsp_valid   = r_rsp_valid;
  assign M_rsp_wr      = r_rsp_wr;
  assign M_rsp_rdata   = r_rsp_rdata;
  assign M_rsp_resp    = r_rsp_resp;
  assign M_rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_axi4l_master_cmdq.sv
// Bench for axi4l_master_cmdq: reactive AXI4-lite slave with per-channel delay
// knobs and a response scoreboard filled when commands are pushed.
module tb_axi4l_master_cmdq;
  localparam int AW = 32, DW = 32, SW = DW/8, DEPTH = 4, TO = 16;

  logic ACLK = 1'b0, ARESETn = 1'b0;
  logic M_cmd_valid = 1'b0, M_cmd_ready, M_cmd_wr = 1'b0;
  logic [AW-1:0] M_cmd_addr = '0;
  logic [DW-1:0] M_cmd_wdata = '0;
  logic [SW-1:0] M_cmd_strb = '0;
  logic M_rsp_valid, M_rsp_wr, M_rsp_timeout, M_busy;
  logic [DW-1:0] M_rsp_rdata;
  logic [1:0] M_rsp_resp;
  logic AWVALID, AWREADY = 1'b0, WVALID, WREADY = 1'b0, BVALID = 1'b0, BREADY;
  logic ARVALID, ARREADY = 1'b0, RVALID = 1'b0, RREADY;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [2:0] AWPROT, ARPROT;
  logic [DW-1:0] WDATA, RDATA = '0;
  logic [SW-1:0] WSTRB;
  logic [1:0] BRESP = 2'b00, RRESP = 2'b00;

  axi4l_master_cmdq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(DEPTH),
                      .TIMEOUT_CYC(TO), .PROT(3'b010)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .M_cmd_valid(M_cmd_valid), .M_cmd_ready(M_cmd_ready), .M_cmd_wr(M_cmd_wr),
    .M_cmd_addr(M_cmd_addr), .M_cmd_wdata(M_cmd_wdata), .M_cmd_strb(M_cmd_strb),
    .M_rsp_valid(M_rsp_valid), .M_rsp_wr(M_rsp_wr), .M_rsp_rdata(M_rsp_rdata),
    .M_rsp_resp(M_rsp_resp), .M_rsp_timeout(M_rsp_timeout), .M_busy(M_busy),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP));

  always #5 ACLK = ~ACLK;

  typedef struct { logic wr; logic [DW-1:0] rdata; logic [1:0] resp; logic tmo; } exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;

  // slave knobs
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic b_en = 1'b1, r_en = 1'b1, rd_fix_en = 1'b0;
  logic [1:0] b_resp = 2'b00, r_resp = 2'b00;
  logic [DW-1:0] rd_fix = '0;

  // slave state
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic aw_got, w_got, ar_got, b_hs, r_hs;
  logic [AW-1:0] ar_addr;

  // Slave drives on negedge; B/R decisions use completion flags from earlier cycles.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0; ar_addr = '0;
    end else begin
      if (BVALID && b_hs) begin
        BVALID = 0; b_hs = 0; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else if (BVALID) b_hs = BREADY;
      else if (aw_got && w_got && b_en) begin
        if (b_cnt >= b_dly) begin BVALID = 1; BRESP = b_resp; b_hs = BREADY; end
        else b_cnt++;
      end
      if (RVALID && r_hs) begin
        RVALID = 0; r_hs = 0; ar_got = 0; ar_cnt = 0; r_cnt = 0;
      end else if (RVALID) r_hs = RREADY;
      else if (ar_got && r_en) begin
        if (r_cnt >= r_dly) begin
          RVALID = 1; RRESP = r_resp; r_hs = RREADY;
          RDATA = rd_fix_en ? rd_fix : (ar_addr ^ 32'hA5A5_0000);
        end else r_cnt++;
      end
      if (AWVALID && !aw_got) begin
        if (aw_cnt >= aw_dly) begin AWREADY = 1; aw_got = 1; end
        else begin AWREADY = 0; aw_cnt++; end
      end else AWREADY = 0;
      if (WVALID && !w_got) begin
        if (w_cnt >= w_dly) begin WREADY = 1; w_got = 1; end
        else begin WREADY = 0; w_cnt++; end
      end else WREADY = 0;
      if (ARVALID && !ar_got) begin
        if (ar_cnt >= ar_dly) begin ARREADY = 1; ar_got = 1; ar_addr = ARADDR; end
        else begin ARREADY = 0; ar_cnt++; end
      end else ARREADY = 0;
    end
  end

  // Scoreboard: every response pulse must match the oldest expectation.
  always @(negedge ACLK) begin
    if (ARESETn && M_rsp_valid) begin
      exp_t e;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got wr=%0b rdata=%h resp=%0b tmo=%0b, required no response",
                 M_rsp_wr, M_rsp_rdata, M_rsp_resp, M_rsp_timeout);
      end else begin
        e = exp_q.pop_front();
        if ({M_rsp_wr, M_rsp_rdata, M_rsp_resp, M_rsp_timeout} !== {e.wr, e.rdata, e.resp, e.tmo}) begin
          n_fail++;
          $display("FAIL rsp_fields: got wr=%0b rdata=%h resp=%0b tmo=%0b, required wr=%0b rdata=%h resp=%0b tmo=%0b",
                   M_rsp_wr, M_rsp_rdata, M_rsp_resp, M_rsp_timeout, e.wr, e.rdata, e.resp, e.tmo);
        end
      end
    end
  end

  // Call at a negedge; returns at the negedge after the accepting edge, valid still high.
  task automatic push(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [SW-1:0] strb, input logic track, input logic [DW-1:0] er,
                      input logic [1:0] eresp, input logic etmo);
    exp_t e;
    M_cmd_wr = wr; M_cmd_addr = addr; M_cmd_wdata = wdata; M_cmd_strb = strb; M_cmd_valid = 1;
    for (int k = 0; k < 100 && !M_cmd_ready; k++) @(negedge ACLK);
    n_chk++;
    if (M_cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL push_ready: got ready=%b, required 1 within 100 cycles", M_cmd_ready);
    end else if (track) begin
      e.wr = wr; e.rdata = er; e.resp = eresp; e.tmo = etmo; exp_q.push_back(e);
    end
    @(negedge ACLK);
  endtask

  task automatic drain_wait(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge ACLK);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rsp_missing: got %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    ARESETn = 0;
    repeat (3) @(negedge ACLK);
    n_chk++;
    if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, M_rsp_valid, M_busy, M_cmd_ready, M_rsp_timeout} !== 9'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, required 0", {AWVALID, WVALID, ARVALID, BREADY, RREADY, M_rsp_valid, M_busy, M_cmd_ready, M_rsp_timeout});
    end
    n_chk++;
    if ({AWADDR, WDATA, WSTRB, ARADDR, M_rsp_rdata, M_rsp_resp} !== '0) begin
      n_fail++; $display("FAIL reset_data: got awaddr=%h wdata=%h, required 0", AWADDR, WDATA);
    end
    ARESETn = 1;
    @(negedge ACLK);
    n_chk++;
    if ({M_cmd_ready, M_busy} !== 2'b10) begin
      n_fail++; $display("FAIL reset_release: got ready/busy=%b, required 10", {M_cmd_ready, M_busy});
    end
  endtask

  task automatic test_single_write;
    @(negedge ACLK);
    push(1, 32'h100, 32'hDEADBEEF, 4'hF, 1, '0, 2'b00, 0);
    M_cmd_valid = 0;
    for (int k = 0; k < 20 && !AWVALID; k++) @(negedge ACLK);
    n_chk++;
    if ({AWVALID, WVALID, AWADDR, WDATA, WSTRB, AWPROT} !== {2'b11, 32'h100, 32'hDEADBEEF, 4'hF, 3'b010}) begin
      n_fail++; $display("FAIL wr_issue: got v=%b%b addr=%h data=%h strb=%h prot=%b, required 11 100 deadbeef f 010",
                         AWVALID, WVALID, AWADDR, WDATA, WSTRB, AWPROT);
    end
    @(negedge ACLK);
    n_chk++;
    if ({AWVALID, WVALID, BREADY} !== 3'b001) begin
      n_fail++; $display("FAIL wr_same_cycle: got aw/w/bready=%b, required 001", {AWVALID, WVALID, BREADY});
    end
    drain_wait(20);
  endtask

  task automatic test_w_before_aw;
    int cnt;
    aw_dly = 3;
    @(negedge ACLK);
    push(1, 32'h104, 32'hCAFEF00D, 4'h3, 1, '0, 2'b00, 0);
    M_cmd_valid = 0;
    for (int k = 0; k < 20 && !AWVALID; k++) @(negedge ACLK);
    n_chk++;
    if ({AWVALID, WVALID} !== 2'b11) begin
      n_fail++; $display("FAIL wfirst_start: got aw/w=%b, required 11", {AWVALID, WVALID});
    end
    cnt = 1;
    @(negedge ACLK);
    n_chk++;
    if ({AWVALID, WVALID} !== 2'b10) begin
      n_fail++; $display("FAIL wfirst_wdrop: got aw/w=%b, required 10", {AWVALID, WVALID});
    end
    while (AWVALID && cnt < 30) begin cnt++; @(negedge ACLK); end
    n_chk++;
    if (cnt != 4) begin
      n_fail++; $display("FAIL wfirst_awhold: got %0d cycles of AWVALID, required 4", cnt);
    end
    drain_wait(20);
    aw_dly = 0;
  endtask

  task automatic test_read;
    int cnt;
    ar_dly = 5; rd_fix_en = 1; rd_fix = 32'h12345678;
    @(negedge ACLK);
    push(0, 32'h200, '0, '0, 1, 32'h12345678, 2'b00, 0);
    M_cmd_valid = 0;
    for (int k = 0; k < 20 && !ARVALID; k++) @(negedge ACLK);
    n_chk++;
    if ({ARVALID, ARADDR, ARPROT, AWVALID} !== {1'b1, 32'h200, 3'b010, 1'b0}) begin
      n_fail++; $display("FAIL rd_issue: got arvalid=%b araddr=%h prot=%b, required 1 200 010", ARVALID, ARADDR, ARPROT);
    end
    cnt = 0;
    while (ARVALID && cnt < 30) begin cnt++; @(negedge ACLK); end
    n_chk++;
    if (cnt != 6) begin
      n_fail++; $display("FAIL rd_arhold: got %0d cycles of ARVALID, required 6", cnt);
    end
    drain_wait(20);
    ar_dly = 0; rd_fix_en = 0;
  endtask

  task automatic test_fifo_full;
    int acc;
    exp_t e;
    aw_dly = 40; b_resp = 2'b01;
    acc = 0;
    @(negedge ACLK);
    for (int c = 0; c < 10; c++) begin
      M_cmd_wr = (acc % 2 == 0); M_cmd_addr = 32'h300 + 32'(acc * 4);
      M_cmd_wdata = 32'h1000 + 32'(acc); M_cmd_strb = 4'hF; M_cmd_valid = 1;
      if (M_cmd_ready) begin
        e.wr = M_cmd_wr; e.tmo = 0;
        e.rdata = M_cmd_wr ? '0 : (M_cmd_addr ^ 32'hA5A5_0000);
        e.resp = M_cmd_wr ? 2'b01 : 2'b00;
        exp_q.push_back(e);
        acc++;
      end
      @(negedge ACLK);
    end
    M_cmd_valid = 0;
    n_chk++;
    if (acc != DEPTH + 1) begin
      n_fail++; $display("FAIL full_count: got %0d accepted, required %0d", acc, DEPTH + 1);
    end
    n_chk++;
    if ({M_cmd_ready, M_busy} !== 2'b01) begin
      n_fail++; $display("FAIL full_ready: got ready/busy=%b, required 01", {M_cmd_ready, M_busy});
    end
    aw_dly = 0;
    drain_wait(200);
    b_resp = 2'b00;
  endtask

  task automatic test_back_to_back;
    @(negedge ACLK);
    push(1, 32'h500, 32'hA, 4'h1, 1, '0, 2'b00, 0);
    push(1, 32'h504, 32'hB, 4'h2, 1, '0, 2'b00, 0);
    push(1, 32'h508, 32'hC, 4'h4, 1, '0, 2'b00, 0);
    M_cmd_valid = 0;
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 30 && !M_rsp_valid; k++) @(negedge ACLK);
      n_chk++;
      if ({M_rsp_valid, AWVALID} !== 2'b10) begin
        n_fail++; $display("FAIL b2b_gap%0d: got rsp/awvalid=%b, required 10", t, {M_rsp_valid, AWVALID});
      end
      @(negedge ACLK);
      n_chk++;
      if (AWVALID !== 1'b1) begin
        n_fail++; $display("FAIL b2b_next%0d: got awvalid=%b, required 1", t, AWVALID);
      end
    end
    drain_wait(30);
  endtask

  task automatic test_timeout;
    int cnt;
    b_en = 0;
    @(negedge ACLK);
    push(1, 32'h400, 32'h55AA55AA, 4'hF, 1, '0, 2'b10, 1);
    M_cmd_valid = 0;
    for (int k = 0; k < 30 && !BREADY; k++) @(negedge ACLK);
    cnt = 0;
    while (!M_rsp_valid && cnt < 40) begin cnt++; @(negedge ACLK); end
    n_chk++;
    if (cnt != TO) begin
      n_fail++; $display("FAIL tmo_latency: got %0d cycles, required %0d", cnt, TO);
    end
    repeat (3) @(negedge ACLK);
    n_chk++;
    if ({M_cmd_ready, BREADY, M_busy} !== 3'b011) begin
      n_fail++; $display("FAIL tmo_drain: got ready/bready/busy=%b, required 011", {M_cmd_ready, BREADY, M_busy});
    end
    b_en = 1;
    for (int k = 0; k < 20 && M_busy; k++) @(negedge ACLK);
    repeat (2) @(negedge ACLK);
    n_chk++;
    if ({M_cmd_ready, M_busy, BREADY} !== 3'b100) begin
      n_fail++; $display("FAIL tmo_recover: got ready/busy/bready=%b, required 100", {M_cmd_ready, M_busy, BREADY});
    end
  endtask

  task automatic test_async_reset;
    aw_dly = 100;
    @(negedge ACLK);
    push(1, 32'h600, 32'h77, 4'hF, 0, '0, 2'b00, 0);
    M_cmd_valid = 0;
    for (int k = 0; k < 20 && !AWVALID; k++) @(negedge ACLK);
    #2 ARESETn = 0;
    #1;
    n_chk++;
    if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, M_rsp_valid, M_busy, M_cmd_ready, AWADDR, WDATA, WSTRB} !== '0) begin
      n_fail++; $display("FAIL arst_outputs: got aw/w=%b%b busy=%b awaddr=%h wdata=%h, required all 0",
                         AWVALID, WVALID, M_busy, AWADDR, WDATA);
    end
    repeat (2) @(negedge ACLK);
    ARESETn = 1; aw_dly = 0;
    @(negedge ACLK);
    n_chk++;
    if ({M_busy, M_cmd_ready, AWVALID} !== 3'b010) begin
      n_fail++; $display("FAIL arst_release: got busy/ready/awvalid=%b, required 010", {M_busy, M_cmd_ready, AWVALID});
    end
    push(1, 32'h700, 32'h88, 4'h8, 1, '0, 2'b00, 0);
    M_cmd_valid = 0;
    drain_wait(20);
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_w_before_aw;
    test_read;
    test_fifo_full;
    test_back_to_back;
    test_timeout;
    test_async_reset;
    repeat (5) @(negedge ACLK);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL final_queue: got %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
